// File: rtl/process_scheduler.sv
// Round-robin preemptive context-switch controller for NPROC process slots.
// Optional build macro SCHED_SWITCH_COUNT_EN adds a saturating dispatch counter output.
module process_scheduler #(
  parameter int NPROC     = 4,
  parameter int ADDR_W    = 32,
  parameter int QUANTUM_W = 16,
  localparam int ID_W     = $clog2(NPROC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [QUANTUM_W-1:0] quantum,
  input  logic                 retire,
  input  logic [ADDR_W-1:0]    cur_pc,
  input  logic                 proc_end,
  input  logic                 load_valid,
  input  logic [ID_W-1:0]      load_id,
  input  logic [ADDR_W-1:0]    load_pc,
  output logic                 switch_req,
  output logic [ADDR_W-1:0]    new_pc,
  output logic [ID_W-1:0]      cur_id,
  output logic                 running,
  output logic                 all_done,
  output logic [NPROC-1:0]     ready_mask
`ifdef SCHED_SWITCH_COUNT_EN
  ,
  output logic [15:0]          switch_count
`endif
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SELECT   = 3'd1;
  localparam logic [2:0] ST_DISPATCH = 3'd2;
  localparam logic [2:0] ST_RUN      = 3'd3;
  localparam logic [2:0] ST_SAVE     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  logic [2:0]           state;
  logic [2:0]           next_state;
  logic [ADDR_W-1:0]    pc_table [NPROC];
  logic [QUANTUM_W-1:0] count;
  logic                 save_to_idle;
  logic [ID_W-1:0]      sel;
  logic                 found;
  logic                 expire;
  logic                 load_accept;
  logic [NPROC-1:0]     mask_next;

  // Rotating search starting just after cur_id; offset NPROC wraps back to cur_id itself.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 1; i <= NPROC; i++) begin
      if (!found && ready_mask[cur_id + ID_W'(i)]) begin
        found = 1'b1;
        sel   = cur_id + ID_W'(i);
      end
    end
  end

  assign expire      = (quantum != '0) && retire && ((count + QUANTUM_W'(1)) == quantum);
  assign load_accept = load_valid &&
                       !((load_id == cur_id) && ((state == ST_RUN) || (state == ST_SAVE)));
  assign running     = (state == ST_RUN);
  assign all_done    = (state == ST_DONE);

  always_comb begin
    mask_next = ready_mask;
    if ((state == ST_RUN) && proc_end) mask_next[cur_id] = 1'b0;
    if (load_accept) mask_next[load_id] = 1'b1;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (enable && (ready_mask != '0)) next_state = ST_SELECT;
      ST_SELECT:   next_state = found ? ST_DISPATCH : ST_DONE;
      ST_DISPATCH: next_state = ST_RUN;
      ST_RUN: begin
        if (proc_end)     next_state = ST_SELECT;
        else if (!enable) next_state = ST_SAVE;
        else if (expire)  next_state = ST_SAVE;
      end
      ST_SAVE:     next_state = save_to_idle ? ST_IDLE : ST_SELECT;
      ST_DONE:     if (load_valid) next_state = enable ? ST_SELECT : ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Dispatch outputs are registered on entry so they are visible throughout the DISPATCH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ready_mask   <= '0;
      for (int i = 0; i < NPROC; i++) pc_table[i] <= '0;
      cur_id       <= ID_W'(NPROC - 1);
      count        <= '0;
      switch_req   <= 1'b0;
      new_pc       <= '0;
      save_to_idle <= 1'b0;
    end else begin
      state      <= next_state;
      ready_mask <= mask_next;
      switch_req <= 1'b0;
      if (load_accept) pc_table[load_id] <= load_pc;
      if (state == ST_SAVE) pc_table[cur_id] <= cur_pc;
      case (state)
        ST_SELECT: begin
          if (found) begin
            switch_req <= 1'b1;
            new_pc     <= pc_table[sel];
            cur_id     <= sel;
            count      <= '0;
          end
        end
        ST_RUN: begin
          if (retire) count <= count + QUANTUM_W'(1);
          if (!proc_end) save_to_idle <= !enable;
        end
        default: ;
      endcase
    end
  end

`ifdef SCHED_SWITCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      switch_count <= '0;
    end else if (load_valid && (state == ST_DONE)) begin
      switch_count <= '0;
    end else if ((state == ST_SELECT) && found && (switch_count != 16'hFFFF)) begin
      switch_count <= switch_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_process_scheduler.sv
// Self-checking bench for process_scheduler: directed scenarios plus a randomized run
// compared against a slot-level reference model (saved PCs, ready set, round-robin pick).
module tb_process_scheduler;

  localparam int NPROC  = 4;
  localparam int ADDR_W = 32;
  localparam int QW     = 16;
  localparam int IDW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable;
  logic [QW-1:0]     quantum;
  logic              retire;
  logic [ADDR_W-1:0] cur_pc;
  logic              proc_end;
  logic              load_valid;
  logic [IDW-1:0]    load_id;
  logic [ADDR_W-1:0] load_pc;
  logic              switch_req;
  logic [ADDR_W-1:0] new_pc;
  logic [IDW-1:0]    cur_id;
  logic              running;
  logic              all_done;
  logic [NPROC-1:0]  ready_mask;
`ifdef SCHED_SWITCH_COUNT_EN
  logic [15:0]       switch_count;
`endif

  process_scheduler #(.NPROC(NPROC), .ADDR_W(ADDR_W), .QUANTUM_W(QW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .quantum(quantum), .retire(retire),
    .cur_pc(cur_pc), .proc_end(proc_end), .load_valid(load_valid), .load_id(load_id),
    .load_pc(load_pc), .switch_req(switch_req), .new_pc(new_pc), .cur_id(cur_id),
    .running(running), .all_done(all_done), .ready_mask(ready_mask)
`ifdef SCHED_SWITCH_COUNT_EN
    , .switch_count(switch_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pulse_base = 0;
  bit done_flag = 1'b0;

  // Reference model: saved PC per slot, set of ready slots, slot last dispatched.
  logic [ADDR_W-1:0] m_pc [NPROC];
  logic [NPROC-1:0]  m_ready;
  int                m_cur;

  always @(negedge clk) if (rst_n && switch_req) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_ready(input int cur);
    for (int k = 1; k <= NPROC; k++) begin
      if (m_ready[(cur + k) % NPROC]) return (cur + k) % NPROC;
    end
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_switch_req"}, switch_req, 1'b0);
    check({tag, "_new_pc"}, new_pc, 0);
    check({tag, "_cur_id"}, cur_id, NPROC - 1);
    check({tag, "_running"}, running, 1'b0);
    check({tag, "_all_done"}, all_done, 1'b0);
    check({tag, "_ready_mask"}, ready_mask, 0);
`ifdef SCHED_SWITCH_COUNT_EN
    check({tag, "_switch_count"}, switch_count, 0);
`endif
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    enable = 1'b0; quantum = '0; retire = 1'b0; cur_pc = '0; proc_end = 1'b0;
    load_valid = 1'b0; load_id = '0; load_pc = '0;
    #1;
    check_reset_outputs(tag);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NPROC; i++) m_pc[i] = '0;
    m_ready = '0;
    m_cur = NPROC - 1;
    pulse_base = pulses;
    done_flag = 1'b0;
  endtask

  task automatic load(input int id, input logic [ADDR_W-1:0] pc);
    load_valid = 1'b1; load_id = IDW'(id); load_pc = pc;
    tick();
    load_valid = 1'b0;
  endtask

  // n = cycles from the triggering edge (or from now, if idle) to the DISPATCH edge.
  task automatic dispatch_check(input int exp_id, input int n, input string tag);
    for (int i = 0; i < n - 1; i++) tick();
    check({tag, "_early"}, switch_req, 1'b0);
    tick();
    check({tag, "_req"}, switch_req, 1'b1);
    check({tag, "_new_pc"}, new_pc, m_pc[exp_id]);
    check({tag, "_cur_id"}, cur_id, exp_id);
    m_cur = exp_id;
    tick();
    check({tag, "_pulse_end"}, switch_req, 1'b0);
    check({tag, "_running"}, running, 1'b1);
    check({tag, "_pc_hold"}, new_pc, m_pc[exp_id]);
    check({tag, "_mask"}, ready_mask, m_ready);
`ifdef SCHED_SWITCH_COUNT_EN
    check({tag, "_switch_count"}, switch_count, 16'(pulses - pulse_base));
`endif
  endtask

  task automatic run_expire(input logic [ADDR_W-1:0] pc, input bit gaps, input string tag);
    cur_pc = pc;
    for (int r = 0; r < int'(quantum); r++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        retire = 1'b0;
        tick();
      end
      retire = 1'b1;
      tick();
    end
    retire = 1'b0;
    m_pc[m_cur] = pc;
    dispatch_check(next_ready(m_cur), 2, tag);
  endtask

  task automatic run_end(input bit with_expire, input string tag);
    int nxt;
    retire = 1'b0;
    if (with_expire) begin
      for (int r = 0; r < int'(quantum) - 1; r++) begin
        retire = 1'b1;
        tick();
      end
      retire = 1'b1;
    end
    proc_end = 1'b1;
    tick();
    proc_end = 1'b0;
    retire = 1'b0;
    m_ready[m_cur] = 1'b0;
    nxt = next_ready(m_cur);
    if (nxt < 0) begin
      tick();
      check({tag, "_all_done"}, all_done, 1'b1);
      check({tag, "_mask_empty"}, ready_mask, 0);
      check({tag, "_not_running"}, running, 1'b0);
      done_flag = 1'b1;
    end else begin
      dispatch_check(nxt, 1, tag);
    end
  endtask

  task automatic run_pause(input logic [ADDR_W-1:0] pc, input string tag);
    enable = 1'b0;
    cur_pc = pc;
    tick();
    tick();
    check({tag, "_idle_running"}, running, 1'b0);
    m_pc[m_cur] = pc;
    enable = 1'b1;
    dispatch_check(next_ready(m_cur), 2, tag);
  endtask

  task automatic restart_from_done(input int id, input logic [ADDR_W-1:0] pc, input string tag);
    pulse_base = pulses;
    load(id, pc);
    m_pc[id] = pc;
    m_ready[id] = 1'b1;
    done_flag = 1'b0;
    check({tag, "_done_clear"}, all_done, 1'b0);
    dispatch_check(next_ready(m_cur), 1, tag);
  endtask

  task automatic load_during_run(input bit to_cur, input string tag);
    int id;
    logic [ADDR_W-1:0] pc;
    pc = {$urandom_range(0, 32'h00FF_FFFF), 2'b00};
    id = to_cur ? m_cur : (m_cur + 1 + $urandom_range(0, NPROC - 2)) % NPROC;
    load(id, pc);
    if (!to_cur) begin
      m_pc[id] = pc;
      m_ready[id] = 1'b1;
    end
    check({tag, "_mask"}, ready_mask, m_ready);
    check({tag, "_still_running"}, running, 1'b1);
  endtask

  initial begin
    int saved_pulses;
    int op;
    rst_n = 1'b0;
    enable = 1'b0; quantum = '0; retire = 1'b0; cur_pc = '0; proc_end = 1'b0;
    load_valid = 1'b0; load_id = '0; load_pc = '0;
    tick();
    tick();

    // Two slots rotating on quantum expiry, wrap 2 -> 0 skipping empty slots.
    do_reset("rst1");
    quantum = 16'd3;
    load(0, 32'h100); m_pc[0] = 32'h100; m_ready[0] = 1'b1;
    load(2, 32'h400); m_pc[2] = 32'h400; m_ready[2] = 1'b1;
    check("loaded_mask", ready_mask, 4'b0101);
    enable = 1'b1;
    dispatch_check(0, 2, "first_dispatch");
    run_expire(32'h10C, 1'b0, "expire_0_to_2");
    run_expire(32'h40C, 1'b0, "expire_2_to_0");

    // Only one ready slot: it is reselected with its saved PC.
    do_reset("rst2");
    quantum = 16'd2;
    load(1, 32'h200); m_pc[1] = 32'h200; m_ready[1] = 1'b1;
    enable = 1'b1;
    dispatch_check(1, 2, "single_dispatch");
    run_expire(32'h208, 1'b0, "self_reselect");

    // proc_end wins over a simultaneous expiry, then completion of the last slot.
    do_reset("rst3");
    quantum = 16'd3;
    load(0, 32'h500); m_pc[0] = 32'h500; m_ready[0] = 1'b1;
    load(2, 32'h600); m_pc[2] = 32'h600; m_ready[2] = 1'b1;
    enable = 1'b1;
    dispatch_check(0, 2, "pe_dispatch");
    run_end(1'b1, "end_and_expire");
    run_end(1'b0, "end_last");
    restart_from_done(1, 32'h700, "restart");

    // No preemption with quantum 0, then enable drop and re-enable.
    quantum = '0;
    saved_pulses = pulses;
    retire = 1'b1;
    cur_pc = 32'h7F0;
    repeat (1000) tick();
    retire = 1'b0;
    check("q0_no_switch", pulses, saved_pulses);
    check("q0_running", running, 1'b1);
    quantum = 16'd2;
    run_pause(32'h7A0, "pause_resume");
    load_during_run(1'b1, "load_cur_ignored");
    run_expire(32'h7B0, 1'b0, "after_ignored_load");

    // Randomized operation sequence against the reference model.
    do_reset("rst4");
    for (int i = 0; i < 3; i++) begin
      int id;
      logic [ADDR_W-1:0] pc;
      id = $urandom_range(0, NPROC - 1);
      pc = {$urandom_range(0, 32'h00FF_FFFF), 2'b00};
      load(id, pc);
      m_pc[id] = pc;
      m_ready[id] = 1'b1;
    end
    check("rand_loaded_mask", ready_mask, m_ready);
    enable = 1'b1;
    dispatch_check(next_ready(m_cur), 2, "rand_first");
    for (int it = 0; it < 60; it++) begin
      if (done_flag) begin
        restart_from_done($urandom_range(0, NPROC - 1), {$urandom_range(0, 32'h00FF_FFFF), 2'b00},
                          "rand_restart");
      end else begin
        quantum = QW'($urandom_range(1, 4));
        op = $urandom_range(0, 5);
        case (op)
          0: run_expire({$urandom_range(0, 32'h00FF_FFFF), 2'b00}, 1'b1, "rand_expire");
          1: run_end(1'b0, "rand_end");
          2: run_end(1'b1, "rand_end_expire");
          3: run_pause({$urandom_range(0, 32'h00FF_FFFF), 2'b00}, "rand_pause");
          4: load_during_run(1'b0, "rand_load_other");
          default: load_during_run(1'b1, "rand_load_cur");
        endcase
      end
    end

    // Asynchronous reset landing in the SAVE cycle.
    if (done_flag) restart_from_done(0, 32'h900, "pre_save_restart");
    quantum = 16'd1;
    cur_pc = 32'hABC;
    retire = 1'b1;
    tick();
    retire = 1'b0;
    check("in_save_not_running", running, 1'b0);
    check_reset_outputs_async();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic check_reset_outputs_async();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_in_save");
    tick();
    check("rst_in_save_no_pulse", switch_req, 1'b0);
  endtask

endmodule

// File: doc/process_scheduler.md
Name: process_scheduler

Overview:
- Round-robin, preemptive context-switch controller for the multi-process processor.
- Holds a saved-PC table and ready mask for NPROC process slots.
- Counts retired instructions against a programmable quantum.
- On quantum expiry or end-of-process it saves the running PC, selects the next ready slot, and pulses a switch request carrying the new PC to the PC logic.
- Successor to the single-bit process-state/context-change logic: generalised to N slots, with preemption and completion tracking.

Parameters:
NPROC, 4, number of process slots (power of 2, ≥2)
ADDR_W, 32, PC width
QUANTUM_W, 16, quantum counter width
ID_W, $clog2(NPROC), slot index width (derived)

Ports:
Clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  scheduler active; 0 = kernel/OS mode, no dispatch
quantum  input  QUANTUM_W  time slice in retired instructions; 0 = no preemption
retire  input  1  one instruction retired this cycle
cur_pc  input  ADDR_W  PC of next instruction of running process
proc_end  input  1  running process executed its end instruction
load_valid  input  1  write load_pc into slot load_id and mark it ready
load_id  input  ID_W  slot to load
load_pc  input  ADDR_W  start PC for loaded slot
switch_req  output  1  one-cycle pulse: PC must take new_pc
new_pc  output  ADDR_W  PC to dispatch; valid while switch_req=1
cur_id  output  ID_W  running/last-dispatched slot
running  output  1  a process is executing (state RUN)
all_done  output  1  no ready slots after at least one completion
ready_mask  output  NPROC  bit i = slot i ready

Behaviour:
- Reset (async, reset=0) values:
  - state=IDLE; ready_mask=0; pc_table all 0; cur_id=NPROC-1, so the first search starts at slot 0.
  - count=0; switch_req=0; new_pc=0; running=0; all_done=0.
- IDLE:
  - If enable=1 and ready_mask≠0 → SELECT; otherwise stay.
- SELECT (1 cycle):
  - Search the registered ready_mask from (cur_id+1) mod NPROC upward, wrapping; the first set bit becomes sel.
  - If found → DISPATCH; if ready_mask=0 → DONE.
  - If cur_id is the only ready slot, it is reselected.
- DISPATCH (1 cycle):
  - switch_req=1, new_pc=pc_table[sel]; cur_id←sel; count←0; → RUN.
  - new_pc holds its value after the pulse.
- RUN:
  - running=1. Each retire=1 increments count, wrapping at 2^QUANTUM_W.
  - proc_end=1 → clear ready_mask[cur_id]; → SELECT. The PC is not saved.
  - Else if enable=0 → SAVE, then IDLE.
  - Else if quantum≠0 and retire=1 and count+1==quantum → SAVE, then SELECT.
  - Priority: proc_end > enable drop > quantum expiry.
- SAVE (1 cycle):
  - pc_table[cur_id]←cur_pc; → SELECT, or → IDLE if entered on enable drop.
- DONE:
  - all_done=1. A load_valid → SELECT on the next cycle if enable=1, else → IDLE; all_done clears on leaving.
- Loads:
  - Accepted in every state: pc_table[load_id]←load_pc, ready_mask[load_id]←1.
  - Exception: a load with load_id==cur_id while state ∈ {RUN, SAVE} is ignored.
  - A load in the same cycle as a SELECT search is visible to the next search, not the current one.
  - A load in the same cycle as a proc_end clear on a different slot applies both.
- Latency:
  - Quantum expiry retire edge → SAVE → SELECT → DISPATCH: switch_req appears 3 cycles after the expiring retire.
  - proc_end → switch_req: 2 cycles.
- Reset mid-operation: all state returns to reset values immediately; no pulse is emitted.

Optional Feature:
SCHED_SWITCH_COUNT_EN
- Defined: adds output switch_count [15:0].
  - Resets to 0.
  - Increments on every DISPATCH cycle, saturating at 16'hFFFF.
  - Clears when a load_valid arrives while all_done=1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, load slot0=0x100 and slot2=0x400, enable=1, quantum=3 → switch_req with new_pc=0x100, cur_id=0. After 3 retires, cur_pc=0x10C: +3 cycles switch_req new_pc=0x400, cur_id=2, and pc_table[0]=0x10C.
- Continue with 3 more retires at cur_pc=0x40C → redispatch slot 0 with new_pc=0x10C (wrap 2→0 skipping 1, 3).
- Single ready slot 1 (pc 0x200), quantum=2, 2 retires with cur_pc=0x208 → switch_req new_pc=0x208, cur_id=1 (self-reselect).
- proc_end and quantum expiry in the same cycle on slot 0, slot 2 ready → ready_mask[0]=0, no save, switch_req new_pc=pc_table[2] 2 cycles later. Then proc_end on slot 2 → all_done=1, ready_mask=0.
- quantum=0, 1000 retires → no switch_req. Drop enable in RUN → SAVE then IDLE, running=0, pc saved. Re-enable → same slot dispatched with saved PC.
- load_valid to cur_id during RUN → ignored, ready_mask/pc_table unchanged. Assert reset during SAVE → all outputs at reset values on the same edge. With SCHED_SWITCH_COUNT_EN, switch_count equals the number of switch_req pulses.
